// File: rtl/vga_line_buffer_if.sv
// Purpose: bundles the PPU write side, VGA read side and palette port of the line buffer.
// Latency: none (wires only).
// Backpressure: none; the PPU and VGA sides are never stalled.
interface vga_line_buffer_if;
  logic        ppu_pixel_valid;
  logic [5:0]  ppu_color;
  logic        ppu_line_end;
  logic        ppu_frame_start;
  logic [9:0]  next_pixel_x;
  logic [14:0] pixel;
  logic        sync;
  logic        pal_we;
  logic [5:0]  pal_addr;
  logic [14:0] pal_data;
  logic        overflow;

  modport slave (
    input  ppu_pixel_valid, ppu_color, ppu_line_end, ppu_frame_start,
    input  next_pixel_x, pal_we, pal_addr, pal_data,
    output pixel, sync, overflow
  );

  modport master (
    output ppu_pixel_valid, ppu_color, ppu_line_end, ppu_frame_start,
    output next_pixel_x, pal_we, pal_addr, pal_data,
    input  pixel, sync, overflow
  );
endinterface

// File: rtl/vga_line_buffer.sv
// Purpose: double-banked NES scanline buffer with palette lookup feeding a 2x-wide VGA scan.
// Latency: pixel is registered one cycle after next_pixel_x; sync one cycle after frame start.
// Backpressure: none; excess PPU pixels in a line are dropped and flagged in overflow.
module vga_line_buffer (
  input  logic             clk,
  input  logic             rst_n,
  vga_line_buffer_if.slave bus
);

  // Two 256-entry banks packed as one array: address = {bank, column}.
  logic [5:0]  bank_mem [0:511];
  logic [14:0] pal_mem  [0:63];

  logic [8:0]  wx_q, wx_d;
  logic        wb_q, wb_d;
  logic        ovf_q, ovf_d;
  logic        sync_q, sync_d;
  logic [14:0] pixel_q, pixel_d;

  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [8:0]  rd_addr;
  logic [5:0]  rd_color;

  // Column 256 is the "line full" state; bit 8 set means no more room.
  assign wr_en   = bus.ppu_pixel_valid & ~wx_q[8];
  assign wr_addr = {wb_q, wx_q[7:0]};

  // Each stored pixel covers two VGA columns, so column bit 0 is ignored.
  assign rd_addr  = {bus.next_pixel_x[9], bus.next_pixel_x[8:1]};
  // Reads happen before the edge's writes land, so same-cycle collisions see old data.
  assign rd_color = bank_mem[rd_addr];
  assign pixel_d  = pal_mem[rd_color];

  // Write-side next state: frame start beats line end; the pixel itself uses the old wb/wx.
  always_comb begin
    wx_d   = wx_q;
    wb_d   = wb_q;
    ovf_d  = ovf_q;
    sync_d = bus.ppu_frame_start;
    if (wr_en) begin
      wx_d = wx_q + 9'd1;
    end
    if (bus.ppu_pixel_valid && wx_q[8]) begin
      ovf_d = 1'b1;
    end
    if (bus.ppu_frame_start) begin
      wx_d  = 9'd0;
      wb_d  = 1'b0;
      ovf_d = 1'b0;
    end else if (bus.ppu_line_end) begin
      wx_d = 9'd0;
      wb_d = ~wb_q;
    end
  end

  // Line bank and palette storage; deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_mem[wr_addr] <= bus.ppu_color;
    end
    if (bus.pal_we) begin
      pal_mem[bus.pal_addr] <= bus.pal_data;
    end
  end

  // Control state and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wx_q    <= 9'd0;
      wb_q    <= 1'b0;
      ovf_q   <= 1'b0;
      sync_q  <= 1'b0;
      pixel_q <= 15'd0;
    end else begin
      wx_q    <= wx_d;
      wb_q    <= wb_d;
      ovf_q   <= ovf_d;
      sync_q  <= sync_d;
      pixel_q <= pixel_d;
    end
  end

  assign bus.pixel    = pixel_q;
  assign bus.sync     = sync_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_vga_line_buffer.sv
// Purpose: directed bench for vga_line_buffer with a reference model and literal spot checks.
// Latency: model predicts outputs one cycle after each edge's inputs.
// Backpressure: none exercised; the DUT never stalls.
module tb_vga_line_buffer;

  logic clk;
  logic rst_n;
  bit   chk_en;
  int   n_cmp;
  int   n_bad;

  vga_line_buffer_if bus ();

  vga_line_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: storage as plain arrays with "has been written" flags.
  logic [5:0]  m_bank [512];
  bit          m_bk   [512];
  logic [14:0] m_pal  [64];
  bit          m_pk   [64];
  int          m_wx;
  bit          m_wb;
  bit          m_ovf;
  bit          m_sync;
  logic [14:0] m_pix;
  bit          m_pixk;
  int          m_ra;
  int          m_wa;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model update: read sees pre-edge contents, then writes and line/frame bookkeeping apply.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wx   <= 0;
      m_wb   <= 1'b0;
      m_ovf  <= 1'b0;
      m_sync <= 1'b0;
      m_pix  <= 15'd0;
      m_pixk <= 1'b1;
    end else begin
      m_ra = bus.next_pixel_x[9] ? 256 + int'(bus.next_pixel_x[8:1]) : int'(bus.next_pixel_x[8:1]);
      if (m_bk[m_ra] && m_pk[m_bank[m_ra]]) begin
        m_pix  <= m_pal[m_bank[m_ra]];
        m_pixk <= 1'b1;
      end else begin
        m_pixk <= 1'b0;
      end
      if (bus.pal_we) begin
        m_pal[bus.pal_addr] <= bus.pal_data;
        m_pk[bus.pal_addr]  <= 1'b1;
      end
      m_wa = m_wb ? 256 + m_wx : m_wx;
      if (bus.ppu_pixel_valid && m_wx < 256) begin
        m_bank[m_wa] <= bus.ppu_color;
        m_bk[m_wa]   <= 1'b1;
      end
      m_sync <= bus.ppu_frame_start;
      if (bus.ppu_frame_start) m_ovf <= 1'b0;
      else if (bus.ppu_pixel_valid && m_wx >= 256) m_ovf <= 1'b1;
      if (bus.ppu_frame_start) begin
        m_wb <= 1'b0;
        m_wx <= 0;
      end else if (bus.ppu_line_end) begin
        m_wb <= ~m_wb;
        m_wx <= 0;
      end else if (bus.ppu_pixel_valid && m_wx < 256) begin
        m_wx <= m_wx + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sync", 32'(bus.sync), 32'(m_sync));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      if (m_pixk) check("pixel", 32'(bus.pixel), 32'(m_pix));
    end
  end

  task automatic tick();
    @(negedge clk);
    bus.ppu_pixel_valid = 1'b0;
    bus.ppu_line_end    = 1'b0;
    bus.ppu_frame_start = 1'b0;
    bus.pal_we          = 1'b0;
  endtask

  task automatic set_pal(input logic [5:0] a, input logic [14:0] d);
    bus.pal_we   = 1'b1;
    bus.pal_addr = a;
    bus.pal_data = d;
    tick();
  endtask

  task automatic push(input logic [5:0] c);
    bus.ppu_pixel_valid = 1'b1;
    bus.ppu_color       = c;
    tick();
  endtask

  task automatic read_px(input logic [9:0] x);
    bus.next_pixel_x = x;
    tick();
  endtask

  task automatic frame();
    bus.ppu_frame_start = 1'b1;
    tick();
  endtask

  task automatic line();
    bus.ppu_line_end = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    chk_en = 1'b0;
    rst_n = 1'b0;
    bus.ppu_pixel_valid = 1'b0;
    bus.ppu_color       = 6'd0;
    bus.ppu_line_end    = 1'b0;
    bus.ppu_frame_start = 1'b0;
    bus.next_pixel_x    = 10'd0;
    bus.pal_we          = 1'b0;
    bus.pal_addr        = 6'd0;
    bus.pal_data        = 15'd0;
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_pixel", 32'(bus.pixel), 32'd0);
    check("reset_sync", 32'(bus.sync), 32'd0);
    check("reset_overflow", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;

    // Full line of one color, then both VGA halves of bank 0.
    set_pal(6'h21, 15'h7C1F);
    set_pal(6'h22, 15'h03E0);
    for (int i = 0; i < 256; i++) push(6'h21);
    line();
    for (int x = 0; x < 512; x++) begin
      read_px(10'(x));
      if (x == 0 || x == 255 || x == 511) check("path_pixel", 32'(bus.pixel), 32'h7C1F);
    end
    // wb must now be 1: the next pixel lands in bank 1 column 0.
    push(6'h22);
    read_px(10'h200);
    check("path_wb1", 32'(bus.pixel), 32'h03E0);
    read_px(10'h000);
    check("path_bank0_kept", 32'(bus.pixel), 32'h7C1F);

    // Identity palette and a ramp line: each stored pixel shows twice.
    for (int k = 0; k < 64; k++) set_pal(6'(k), 15'(k));
    frame();
    for (int i = 0; i < 256; i++) push(6'(i));
    for (int i = 0; i < 256; i++) begin
      read_px(10'(2 * i));
      check("dbl_even", 32'(bus.pixel), 32'(i % 64));
      read_px(10'(2 * i + 1));
      check("dbl_odd", 32'(bus.pixel), 32'(i % 64));
    end

    // Overflow: 300 pixels, the 257th onward is dropped and flags overflow.
    frame();
    for (int i = 0; i < 300; i++) begin
      push(6'(i * 3));
      if (i == 255) check("ovf_at_256", 32'(bus.overflow), 32'd0);
      if (i == 256) check("ovf_at_257", 32'(bus.overflow), 32'd1);
    end
    check("ovf_sticky", 32'(bus.overflow), 32'd1);
    for (int c = 0; c < 256; c++) begin
      read_px(10'(2 * c));
      check("ovf_cols", 32'(bus.pixel), 32'((c * 3) % 64));
    end
    frame();
    check("ovf_clear", 32'(bus.overflow), 32'd0);
    check("sync_pulse", 32'(bus.sync), 32'd1);
    tick();
    check("sync_one_cycle", 32'(bus.sync), 32'd0);

    // Simultaneous valid + line_end + frame_start.
    line();
    for (int i = 0; i < 5; i++) push(6'd9);
    bus.ppu_pixel_valid = 1'b1;
    bus.ppu_color       = 6'h2A;
    bus.ppu_line_end    = 1'b1;
    bus.ppu_frame_start = 1'b1;
    tick();
    check("simul_sync", 32'(bus.sync), 32'd1);
    check("simul_ovf", 32'(bus.overflow), 32'd0);
    tick();
    check("simul_sync_drop", 32'(bus.sync), 32'd0);
    push(6'h11);
    read_px(10'h20A);
    check("simul_old_pos", 32'(bus.pixel), 32'h2A);
    read_px(10'h20B);
    check("simul_old_pos_dup", 32'(bus.pixel), 32'h2A);
    read_px(10'h000);
    check("simul_new_pos", 32'(bus.pixel), 32'h11);

    // Bank collision at bank 1 column 10, then palette collision on entry 5.
    frame();
    line();
    for (int i = 0; i < 10; i++) push(6'd1);
    push(6'd3);
    frame();
    line();
    for (int i = 0; i < 10; i++) push(6'd1);
    bus.ppu_pixel_valid = 1'b1;
    bus.ppu_color       = 6'd5;
    bus.next_pixel_x    = 10'h214;
    tick();
    check("coll_old", 32'(bus.pixel), 32'd3);
    read_px(10'h214);
    check("coll_new", 32'(bus.pixel), 32'd5);
    bus.pal_we   = 1'b1;
    bus.pal_addr = 6'd5;
    bus.pal_data = 15'h1234;
    tick();
    check("pal_coll_old", 32'(bus.pixel), 32'd5);
    tick();
    check("pal_coll_new", 32'(bus.pixel), 32'h1234);

    // Async reset mid-line with wb=1 and a partial line written.
    frame();
    line();
    for (int i = 0; i < 3; i++) push(6'd1);
    check("pre_reset_pixel", 32'(bus.pixel), 32'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pixel", 32'(bus.pixel), 32'd0);
    check("arst_sync", 32'(bus.sync), 32'd0);
    check("arst_overflow", 32'(bus.overflow), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.ppu_pixel_valid = 1'b1;
    bus.ppu_color       = 6'd7;
    bus.next_pixel_x    = 10'h214;
    tick();
    check("post_reset_read", 32'(bus.pixel), 32'h1234);
    read_px(10'h000);
    check("post_reset_write", 32'(bus.pixel), 32'd7);
    read_px(10'h001);
    check("post_reset_write_dup", 32'(bus.pixel), 32'd7);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_line_buffer.md
VGA_LINE_BUFFER -- requirements
Module: vga_line_buffer

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all logic rising-edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous assert and active-low.
REQ-003 SHALL have port ppu_pixel_valid, input, 1: ppu_color carries one NES pixel this cycle.
REQ-004 SHALL have port ppu_color, input, 6: NES palette index of the current PPU pixel.
REQ-005 SHALL have port ppu_line_end, input, 1: one-cycle pulse marking the end of a PPU scanline.
REQ-006 SHALL have port ppu_frame_start, input, 1: one-cycle pulse marking the start of a new PPU frame.
REQ-007 SHALL have port next_pixel_x, input, 10: VGA read request; bit 9 selects the bank and bits 8:0 give the 512-wide VGA column.
REQ-008 SHALL have port pixel, output, 15: RGB555 {b[14:10], g[9:5], r[4:0]} for the column requested on the previous cycle.
REQ-009 SHALL have port sync, output, 1: registered one-cycle pulse to the VGA timing stage on each frame start.
REQ-010 SHALL have port pal_we, input, 1: palette write strobe.
REQ-011 SHALL have port pal_addr, input, 6: palette write address.
REQ-012 SHALL have port pal_data, input, 15: palette write data in RGB555.
REQ-013 SHALL have port overflow, output, 1: sticky flag; more than 256 pixels arrived within one line.

Function
REQ-014 SHALL hold two line banks, each 256 x 6 bits, plus a 64 x 15 palette RAM.
REQ-015 SHALL keep a write column wx (9 bits) and a write bank wb (1 bit).
REQ-016 On ppu_pixel_valid with wx<256, SHALL write ppu_color to bank[wb][wx] and increment wx.
REQ-017 On ppu_pixel_valid with wx==256, SHALL drop the pixel, leave wx at 256, and set overflow.
REQ-018 On ppu_line_end, SHALL toggle wb and clear wx to 0 at the next edge.
REQ-019 If ppu_pixel_valid and ppu_line_end occur in the same cycle, SHALL write the pixel to the old wb/wx first, then apply the toggle and clear.
REQ-020 On ppu_frame_start, SHALL set wb=0, wx=0, overflow=0, and sync=1 for exactly one cycle; otherwise sync=0.
REQ-021 ppu_frame_start SHALL take priority over a simultaneous ppu_line_end; a simultaneous valid pixel SHALL still be written at the old wb/wx.
REQ-022 Read address SHALL be {next_pixel_x[9], next_pixel_x[8:1]}, so each NES pixel appears in two adjacent VGA columns.
REQ-023 pixel SHALL be registered as palette[bank[addr]], with exactly one cycle of latency from next_pixel_x.
REQ-024 A read and a write to the same bank entry in the same cycle SHALL return the pre-write contents.
REQ-025 pal_we SHALL write palette[pal_addr] at the edge.
REQ-026 A palette write and a read of the same entry in the same cycle SHALL return the old palette value.
REQ-027 The read path SHALL never stall and SHALL be independent of the write-side state.
REQ-028 Line banks and palette contents SHALL be undefined after power-up and SHALL NOT be cleared by reset.

Reset
REQ-029 While rst_n=0, SHALL hold pixel=0, sync=0, overflow=0, wx=0, wb=0, asynchronously.
REQ-030 After rst_n deasserts, the first write and the first read SHALL take effect on the first rising edge.
REQ-031 Reset asserted mid-line SHALL abandon the partial line; writes resume at bank 0, column 0.

Verification
REQ-032 Pixel path: load palette[0x21]=0x7C1F; write 256 pixels of 0x21 into bank 0; pulse ppu_line_end; drive next_pixel_x=0x000..0x1FF -> pixel=0x7C1F one cycle after each request; wb=1.
REQ-033 Doubling: bank 0 holds a ramp color[i]=i mod 64 with palette[k]=k; read x=2i and x=2i+1 -> both return i mod 64.
REQ-034 Overflow: 300 valid pixels in one line -> overflow=1 from the 257th pixel; columns 0..255 hold the first 256 values; ppu_frame_start -> overflow=0 and sync pulses for 1 cycle.
REQ-035 Simultaneous events: valid + line_end + frame_start in the same cycle -> pixel written at the old wb/wx; then wb=0, wx=0, sync=1 for one cycle.
REQ-036 Collision: write color 5 over color 3 at bank 1 col 10 while reading next_pixel_x=0x214 in the same cycle -> pixel=palette[3]; the following read returns palette[5].
REQ-037 Async reset: drop rst_n mid-line between edges -> pixel=0 and sync=0 immediately; after release, the next write lands at bank 0, col 0.
